// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 8-requester round-robin arbiter driving the select lines of
// a shared 8:1 single-bit mux and registering the mux output during a grant.
// Optional feature macro: GRANT_TIMEOUT_EN (bounds each grant to MAX_HOLD cycles).
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mux_y,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       y_q,
  output logic       done,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       y_d;
  logic       done_q, done_d;
  logic       found;
  logic [2:0] pick;

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("mux_rr_arbiter: MAX_HOLD must be within 2..255");
  end

  // Round-robin search starting just above the last granted index.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!found && req[3'(ptr_q + 3'(i))]) begin
        found = 1'b1;
        pick  = 3'(ptr_q + 3'(i));
      end
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    y_d     = y_q;
    done_d  = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          grant_d = 8'(1) << pick;
          busy_d  = 1'b1;
          ptr_d   = pick;
`ifdef GRANT_TIMEOUT_EN
          hold_d  = 8'd1;
`endif
        end
      end
      GRANT: begin
        y_d = mux_y;
        if (req[sel_q]) begin
`ifdef GRANT_TIMEOUT_EN
          if (hold_q == 8'(MAX_HOLD)) begin
            // Forced end: ptr already holds sel, so this requester is searched last.
            state_d   = IDLE;
            grant_d   = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
      done_q  <= done_d;
`ifdef GRANT_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef GRANT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; models the external 8:1 mux.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] mux_data = '0;
  logic       mux_y;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       y_q;
  logic       done;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mux_y = mux_data[sel];

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mux_y   (mux_y),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .y_q     (y_q),
    .done    (done),
    .timeout (timeout)
  );

  task automatic apply_reset();
    req      = '0;
    mux_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 8'hFF;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, grant, busy, y_q, done, timeout} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got sel=%0d grant=%h busy=%b y=%b done=%b to=%b exp all 0",
               sel, grant, busy, y_q, done, timeout);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got grant=%h busy=%b exp 00/0", grant, busy);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    req = 8'h04;
    @(negedge clk);
    total++;
    if (grant !== 8'h04 || sel !== 3'd2) begin
      bad++;
      $display("FAIL basic_grant got grant=%h sel=%0d exp 04/2", grant, sel);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy cycle=%0d got busy=%b done=%b exp 1/0", i, busy, done);
      end
      if (i < 4) @(negedge clk);
    end
    req = 8'h00;
    @(negedge clk);
    total++;
    if ({grant, busy, done, sel} !== {8'h00, 1'b0, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL basic_release got grant=%h busy=%b done=%b sel=%0d exp 00/0/1/2",
               grant, busy, done, sel);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || grant !== 8'h00) begin
      bad++;
      $display("FAIL basic_done_pulse got done=%b grant=%h exp 0/00", done, grant);
    end
    // ptr is 2: search begins at 3, so 4 wins over 0
    req = 8'h11;
    @(negedge clk);
    total++;
    if (grant !== 8'h10 || sel !== 3'd4) begin
      bad++;
      $display("FAIL basic_ptr got grant=%h sel=%0d exp 10/4", grant, sel);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [7:0] exp;
    apply_reset();
    req = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      exp = 8'h01 << (i % 8);
      total++;
      if (grant !== exp || busy !== 1'b1) begin
        bad++;
        $display("FAIL fair_grant step=%0d got grant=%h busy=%b exp %h/1", i, grant, busy, exp);
      end
      req = ~exp;
      @(negedge clk);
      total++;
      if ({grant, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL fair_gap step=%0d got grant=%h busy=%b done=%b exp 00/0/1",
                 i, grant, busy, done);
      end
      req = 8'hFF;
      @(negedge clk);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 8'h20;
    @(negedge clk);
    total++;
    if (grant !== 8'h20) begin
      bad++;
      $display("FAIL wrap_first got grant=%h exp 20", grant);
    end
    req = 8'h00;
    @(negedge clk);
    req = 8'h21;
    @(negedge clk);
    total++;
    if (grant !== 8'h01 || sel !== 3'd0) begin
      bad++;
      $display("FAIL wrap_next got grant=%h sel=%0d exp 01/0", grant, sel);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 8'h04;
    @(negedge clk);
    req = 8'hFC;
    @(negedge clk);
    total++;
    if (grant !== 8'h04 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ignore got grant=%h busy=%b exp 04/1", grant, busy);
    end
    req = 8'h08;
    @(negedge clk);
    total++;
    if ({grant, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_release got grant=%h busy=%b done=%b exp 00/0/1", grant, busy, done);
    end
    @(negedge clk);
    total++;
    if (grant !== 8'h08 || sel !== 3'd3) begin
      bad++;
      $display("FAIL b2b_regrant got grant=%h sel=%0d exp 08/3", grant, sel);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_ydata();
    logic [2:0] pattern;
    apply_reset();
    pattern = 3'b101;
    req = 8'h08;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mux_data = pattern[i] ? 8'h08 : 8'hF7;
      @(negedge clk);
      total++;
      if (y_q !== pattern[i]) begin
        bad++;
        $display("FAIL ydata_follow step=%0d got y=%b exp %b", i, y_q, pattern[i]);
      end
    end
    req = 8'h00;
    @(negedge clk);
    total++;
    if (y_q !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ydata_release got y=%b busy=%b exp 1/0", y_q, busy);
    end
    mux_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (y_q !== 1'b1) begin
      bad++;
      $display("FAIL ydata_hold got y=%b exp 1", y_q);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 8'h40;
    @(negedge clk);
    total++;
    if (grant !== 8'h40 || sel !== 3'd6) begin
      bad++;
      $display("FAIL rstmid_grant got grant=%h sel=%0d exp 40/6", grant, sel);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (grant !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
      bad++;
      $display("FAIL rstmid_async got grant=%h busy=%b sel=%0d exp 00/0/0", grant, busy, sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hC0;
    @(negedge clk);
    total++;
    if (grant !== 8'h40 || sel !== 3'd6) begin
      bad++;
      $display("FAIL rstmid_ptr got grant=%h sel=%0d exp 40/6", grant, sel);
    end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 8'h01;
    @(negedge clk);
`ifdef GRANT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grant !== 8'h01 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_hold cycle=%0d got grant=%h to=%b exp 01/0", i, grant, timeout);
      end
      @(negedge clk);
    end
    total++;
    if ({grant, busy, done, timeout} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL timeout_fire got grant=%h busy=%b done=%b to=%b exp 00/0/1/1",
               grant, busy, done, timeout);
    end
    @(negedge clk);
    total++;
    if ({grant, done, timeout} !== {8'h01, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL timeout_regrant got grant=%h done=%b to=%b exp 01/0/0", grant, done, timeout);
    end
`else
    for (int i = 0; i < 20; i++) begin
      total++;
      if (grant !== 8'h01 || timeout !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL notimeout_hold cycle=%0d got grant=%h to=%b done=%b exp 01/0/0",
                 i, grant, timeout, done);
      end
      @(negedge clk);
    end
`endif
    req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_wrap();
    test_back_to_back();
    test_ydata();
    test_reset_mid_grant();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- 8-requester round-robin arbiter that owns the select lines of the shared 8:1 single-bit mux.
- Grants one requester at a time and drives the mux select with the granted index.
- Registers the mux output while a grant is active, so downstream logic sees a clean, stable sample.
- Sits directly in front of the 8:1 mux: sel feeds the mux select, and the mux output returns on mux_y.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles. Used only when GRANT_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i wants the mux.
- mux_y  input  1  Y output of the 8:1 mux (combinational from sel).
- sel  output  3  registered select to the mux; equals the granted index.
- grant  output  8  registered one-hot grant; all zero when idle.
- busy  output  1  high while in GRANT state.
- y_q  output  1  mux_y registered every GRANT cycle; holds its last value otherwise.
- done  output  1  one-cycle pulse on the cycle after a grant ends.
- timeout  output  1  one-cycle pulse when a grant is force-ended. Tied 0 without the macro.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, sel=0, grant=0, busy=0, y_q=0, done=0, timeout=0.
  - Priority pointer ptr=7, so requester 0 has top priority first.
  - Hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - Each edge, search req starting at index (ptr+1) mod 8, upward with wrap-around.
  - On the first set bit k: next state GRANT, sel=k, grant=1<<k, busy=1, ptr=k, hold counter=1.
  - If req==0: remain IDLE; outputs unchanged (grant=0).
  - Latency: req asserted before edge N -> grant visible after edge N.
- GRANT:
  - Each edge, y_q<=mux_y.
  - If req[sel]==1: stay in GRANT, hold counter increments (saturating).
  - If req[sel]==0: next state IDLE, grant=0, busy=0, done=1 for one cycle; sel retains its value.
  - Changes on other req bits are ignored during GRANT.
- Arbitration gap: at least one IDLE cycle separates consecutive grants.
- Fairness:
  - Under continuous all-ones req, grants cycle 0,1,…,7,0 in order.
  - Each requester is guaranteed service within 8 grants.
- done and timeout are cleared on every cycle they are not being set.
- Reset mid-grant: grant drops immediately (asynchronous) and ptr returns to 7.
- Simultaneous release and new request in the same cycle: release is taken first; the new request is arbitrated in the following IDLE cycle.
- Requester i deasserting req[i] while not granted has no effect.

Optional Feature:
- Macro GRANT_TIMEOUT_EN.
- Defined:
  - If hold counter reaches MAX_HOLD while req[sel] is still 1, force next state IDLE.
  - On that edge: grant=0, busy=0, done=1, timeout=1 (one cycle each).
  - The timed-out requester moves behind all others by pointer rotation.
  - A lone requester is re-granted after the one-cycle IDLE gap.
- Not defined:
  - Grants last indefinitely while the request holds.
  - Hold counter is removed; timeout is constant 0.

Test Plan:
- Reset then req=8'b0000_0100 held 5 cycles, then 0 → grant=8'h04, sel=2 one cycle after req; busy high for 5 cycles; done pulses 1 cycle after the drop; ptr=2.
- req=8'hFF held, each granted requester drops after 1 cycle and re-requests → grant sequence 01,02,04,…,80,01; one idle cycle between grants.
- After serving index 5, set req=8'b0010_0001 → requester 0 granted (wrap from 6), not 5.
- During grant to 3, drive mux data so mux_y toggles 1,0,1 → y_q follows with one-cycle lag; after release y_q holds last value.
- Pull rst_n low mid-grant to 6 → grant=0, busy=0 without a clock edge; after release, req=8'hC0 → grant to 6 (ptr reset to 7, search starts at 0).
- GRANT_TIMEOUT_EN, MAX_HOLD=4, req=8'h01 constant → grant high 4 cycles, timeout+done pulse, one idle cycle, re-grant to 0; without the macro grant stays high indefinitely.
